// File: rtl/writeback_unit.sv
// Register-bank writeback producer: a DEPTH-entry result FIFO that drains one write
// per cycle, and a per-register pending-write scoreboard for decoder RAW checks.
module writeback_unit #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic        clk,
  input  logic        rst_h,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        stall_h,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic        issue_ready,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic [4:0]  rd,
  output logic        write,
  output logic [31:0] write_data
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = DEPTH[AW:0];

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_ent_t;

  wb_ent_t       mem_q [DEPTH];
  wb_ent_t       head;
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   occ_q, occ_d;
  logic          push, pop;

  logic [4:0]    rd_q, rd_d;
  logic          write_q, write_d;
  logic [31:0]   wdata_q, wdata_d;

  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];

  // Ready looks only at registered occupancy; a same-cycle pop never frees a slot early.
  assign wb_ready = (occ_q < FULL);
  assign push     = wb_valid && wb_ready;
  assign pop      = !stall_h && (occ_q != '0);
  assign head     = mem_q[rptr_q];

  always_comb begin
    occ_d = occ_q;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // rd=0 entries are dropped: no write, bank-side outputs keep their last value.
  always_comb begin
    write_d = 1'b0;
    rd_d    = rd_q;
    wdata_d = wdata_q;
    if (pop && head.rd != 5'd0) begin
      write_d = 1'b1;
      rd_d    = head.rd;
      wdata_d = head.data;
    end
  end

  always_comb begin
    for (int r = 0; r < 32; r++) begin
      logic inc, dec;
      cnt_d[r] = cnt_q[r];
      inc = issue_valid && issue_ready && (issue_rd == 5'(r));
      dec = write_d && (rd_d == 5'(r));
      if (inc && !dec)
        cnt_d[r] = cnt_q[r] + 1'b1;
      else if (dec && !inc && cnt_q[r] != '0)
        cnt_d[r] = cnt_q[r] - 1'b1;
      if (r == 0)
        cnt_d[r] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst_h) begin
    if (rst_h) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      occ_q   <= '0;
      rd_q    <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      occ_q   <= occ_d;
      rd_q    <= rd_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= '{rd: wb_rd, data: wb_data};
  end

  assign issue_ready = (cnt_q[issue_rd] != '1) || (issue_rd == 5'd0);
  assign rs1_busy    = (cnt_q[rs1] != '0);
  assign rs2_busy    = (cnt_q[rs2] != '0);

  assign rd         = rd_q;
  assign write      = write_q;
  assign write_data = wdata_q;
endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: queue/counter model checked every negedge,
// plus literal expectations at the key cycles of each scenario.
module tb_writeback_unit;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst_h = 1'b1;
  logic        wb_valid = 1'b0, wb_ready;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        stall_h = 1'b0;
  logic        issue_valid = 1'b0, issue_ready;
  logic [4:0]  issue_rd = '0, rs1 = '0, rs2 = '0;
  logic        rs1_busy, rs2_busy;
  logic [4:0]  rd;
  logic        write;
  logic [31:0] write_data;

  int n_pass = 0, n_total = 0;

  writeback_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_h(rst_h), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd(wb_rd), .wb_data(wb_data), .stall_h(stall_h),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rd(rd), .write(write), .write_data(write_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Model: pending results as a queue, pending writes as plain integer counts.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  int          mcnt[32];
  logic        m_write = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_data = '0;

  initial begin
    bit   push_m, pop_m, irdy;
    ent_t h;
    for (int i = 0; i < 32; i++) mcnt[i] = 0;
    forever begin
      @(posedge clk or posedge rst_h);
      if (rst_h) begin
        mq.delete();
        for (int i = 0; i < 32; i++) mcnt[i] = 0;
        m_write = 1'b0;
        m_rd    = '0;
        m_data  = '0;
      end else begin
        pop_m  = !stall_h && mq.size() > 0;
        push_m = wb_valid && mq.size() < DEPTH;
        irdy   = (issue_rd == 0) || (mcnt[issue_rd] != MAXC);
        if (issue_valid && irdy && issue_rd != 0) mcnt[issue_rd]++;
        m_write = 1'b0;
        if (pop_m) begin
          h = mq.pop_front();
          if (h.rd != 0) begin
            m_write = 1'b1;
            m_rd    = h.rd;
            m_data  = h.d;
            if (mcnt[h.rd] > 0) mcnt[h.rd]--;
          end
        end
        if (push_m) mq.push_back('{wb_rd, wb_data});
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("m_write", write, m_write);
      chk("m_rd", rd, m_rd);
      chk("m_write_data", write_data, m_data);
      chk("m_wb_ready", wb_ready, mq.size() < DEPTH);
      chk("m_issue_ready", issue_ready, (issue_rd == 0) || (mcnt[issue_rd] != MAXC));
      chk("m_rs1_busy", rs1_busy, (rs1 != 0) && (mcnt[rs1] != 0));
      chk("m_rs2_busy", rs2_busy, (rs2 != 0) && (mcnt[rs2] != 0));
    end
  end

  initial begin
    // reset state
    repeat (2) tick();
    chk("rst_write", write, 0);
    chk("rst_rd", rd, 0);
    chk("rst_wdata", write_data, 0);
    chk("rst_wb_ready", wb_ready, 1);
    chk("rst_issue_ready", issue_ready, 1);
    rst_h = 1'b0;
    tick();

    // single result latency
    issue_valid = 1; issue_rd = 5; tick(); issue_valid = 0;
    wb_valid = 1; wb_rd = 5; wb_data = 32'hDEADBEEF; tick(); wb_valid = 0;
    chk("t1_no_bypass", write, 0);
    tick();
    chk("t1_write", write, 1);
    chk("t1_rd", rd, 5);
    chk("t1_data", write_data, 32'hDEADBEEF);
    tick();
    chk("t1_after", write, 0);

    // RAW scoreboard on rd=7
    rs1 = 7; issue_valid = 1; issue_rd = 7; tick(); tick(); issue_valid = 0;
    chk("t2_busy2", rs1_busy, 1);
    wb_valid = 1; wb_rd = 7; wb_data = 32'h70; tick();
    wb_data = 32'h71; tick(); wb_valid = 0;
    chk("t2_busy_after_pop1", rs1_busy, 1);
    tick();
    chk("t2_clear_after_pop2", rs1_busy, 0);
    chk("t2_pop2_data", write_data, 32'h71);
    issue_valid = 1; tick(); issue_valid = 0;
    wb_valid = 1; wb_data = 32'h72; tick(); wb_valid = 0;
    issue_valid = 1; tick(); issue_valid = 0;
    chk("t2_same_edge_write", write, 1);
    chk("t2_same_edge_busy", rs1_busy, 1);
    wb_valid = 1; wb_data = 32'h73; tick(); wb_valid = 0;
    tick();
    chk("t2_final_clear", rs1_busy, 0);

    // full FIFO under stall, then ordered drain
    for (int i = 10; i < 14; i++) begin
      issue_valid = 1; issue_rd = 5'(i); tick();
    end
    issue_valid = 0;
    stall_h = 1; wb_valid = 1;
    for (int i = 0; i < 5; i++) begin
      wb_rd = 5'(10 + i); wb_data = 32'hA0 + 32'(i); tick();
      if (i == 3) chk("t3_full", wb_ready, 0);
    end
    chk("t3_fifth_rejected", wb_ready, 0);
    wb_valid = 0; stall_h = 0; tick();
    chk("t3_first_write", write, 1);
    chk("t3_first_rd", rd, 10);
    chk("t3_ready_back", wb_ready, 1);
    tick(); tick(); tick();
    chk("t3_last_rd", rd, 13);
    chk("t3_last_data", write_data, 32'hA3);
    tick();
    chk("t3_drained", write, 0);

    // rd=0 dropped
    rs1 = 0; wb_valid = 1; wb_rd = 0; wb_data = 32'h1234; tick(); wb_valid = 0;
    tick();
    chk("t4_no_write", write, 0);
    chk("t4_r0_not_busy", rs1_busy, 0);
    tick();

    // saturation of cnt[3]
    issue_valid = 1; issue_rd = 3;
    repeat (7) tick();
    issue_valid = 0;
    chk("t5_sat_rd3", issue_ready, 0);
    issue_rd = 4; #1;
    chk("t5_rd4_ok", issue_ready, 1);
    issue_rd = 3;
    wb_valid = 1; wb_rd = 3; wb_data = 32'h33; tick(); wb_valid = 0;
    tick();
    chk("t5_unsat", issue_ready, 1);
    tick();

    // async reset with entries queued and cnt[9]=2
    issue_valid = 1; issue_rd = 1; tick(); tick();
    issue_rd = 9; tick(); tick(); issue_valid = 0;
    rs2 = 9; stall_h = 1; wb_valid = 1;
    wb_rd = 1; wb_data = 32'hB0; tick();
    wb_rd = 9; wb_data = 32'hB1; tick();
    wb_rd = 9; wb_data = 32'hB2; tick();
    wb_rd = 1; wb_data = 32'hB3; tick();
    wb_valid = 0; stall_h = 0; tick();
    stall_h = 1;
    chk("t6_write_pre", write, 1);
    chk("t6_busy_pre", rs2_busy, 1);
    #1 rst_h = 1;
    #1;
    chk("t6_rst_write", write, 0);
    chk("t6_rst_ready", wb_ready, 1);
    chk("t6_rst_busy", rs2_busy, 0);
    tick();
    rst_h = 0; stall_h = 0;
    repeat (5) begin
      tick();
      chk("t6_no_stale", write, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
